// File: rtl/arm_bp_pkg.sv
// Shared types and helpers for the branch predictor: BTB entry layout, 2-bit
// counter encodings and the prediction record carried down the pipeline.
package arm_bp_pkg;

  localparam int ENTRIES = 16;
  localparam int IDXW    = $clog2(ENTRIES);
  localparam int TAGW    = 32 - IDXW - 2;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  typedef struct packed {
    logic            valid;
    logic [TAGW-1:0] tag;
    logic [31:0]     target;
    logic [1:0]      cnt;
  } btb_entry_t;

  typedef struct packed {
    logic        vld;
    logic        pred;
    logic [31:0] tgt;
    logic [31:0] pc;
  } pred_pipe_t;

  function automatic logic [IDXW-1:0] pc_idx(input logic [31:0] pc);
    return pc[IDXW+1:2];
  endfunction

  function automatic logic [TAGW-1:0] pc_tag(input logic [31:0] pc);
    return pc[31:IDXW+2];
  endfunction

  // Saturating 2-bit counter step: SNT and ST hold at the ends.
  function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == ST)  ? ST  : cnt + 2'd1;
    else       return (cnt == SNT) ? SNT : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer: two asynchronous read ports (fetch lookup
// and execute-stage update check) and one synchronous write port.
module bp_btb
  import arm_bp_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [IDXW-1:0] rd_idx_f,
  output btb_entry_t      rd_entry_f,
  input  logic [IDXW-1:0] rd_idx_e,
  output btb_entry_t      rd_entry_e,
  input  logic            wr_en,
  input  logic [IDXW-1:0] wr_idx,
  input  btb_entry_t      wr_entry
);

  logic            valid_q  [ENTRIES];
  logic [1:0]      cnt_q    [ENTRIES];
  logic [TAGW-1:0] tag_q    [ENTRIES];
  logic [31:0]     target_q [ENTRIES];

  // NOTE: only valid and cnt are reset; tag/target are never consulted while
  // valid is clear, so they live in a reset-free array that maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= WNT;
      end
    end else if (wr_en) begin
      valid_q[wr_idx] <= wr_entry.valid;
      cnt_q[wr_idx]   <= wr_entry.cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      tag_q[wr_idx]    <= wr_entry.tag;
      target_q[wr_idx] <= wr_entry.target;
    end
  end

  always_comb begin
    rd_entry_f.valid  = valid_q[rd_idx_f];
    rd_entry_f.tag    = tag_q[rd_idx_f];
    rd_entry_f.target = target_q[rd_idx_f];
    rd_entry_f.cnt    = cnt_q[rd_idx_f];
    rd_entry_e.valid  = valid_q[rd_idx_e];
    rd_entry_e.tag    = tag_q[rd_idx_e];
    rd_entry_e.target = target_q[rd_idx_e];
    rd_entry_e.cnt    = cnt_q[rd_idx_e];
  end

endmodule

// File: rtl/branch_predictor_ctrl.sv
// Fetch-steering controller: BTB lookup in Fetch, prediction carried F->D->E,
// resolution and BTB training in Execute, plus a saturating mispredict counter.
module branch_predictor_ctrl
  import arm_bp_pkg::*;
#(
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     PCF,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            FlushE,
  input  logic            BranchE,
  input  logic            TakenE,
  input  logic [31:0]     TargetE,
  output logic            PredTakenF,
  output logic [31:0]     PredTargetF,
  output logic            MispredictE,
  output logic [31:0]     RecoverPCE,
  output logic [CNTW-1:0] MispredCount
);

  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

  btb_entry_t rd_f, rd_e, wr_entry;
  logic       wr_en;
  logic       hit_f, hit_e, upd_en;
  pred_pipe_t pipe_d, pipe_e;
  logic       stall_f_unused;

  // Lookup is purely combinational, so a fetch stall has nothing to hold here.
  assign stall_f_unused = StallF;

  bp_btb u_btb (
    .clk        (clk),
    .reset      (reset),
    .rd_idx_f   (pc_idx(PCF)),
    .rd_entry_f (rd_f),
    .rd_idx_e   (pc_idx(pipe_e.pc)),
    .rd_entry_e (rd_e),
    .wr_en      (wr_en),
    .wr_idx     (pc_idx(pipe_e.pc)),
    .wr_entry   (wr_entry)
  );

  always_comb begin
    hit_f       = rd_f.valid && (rd_f.tag == pc_tag(PCF));
    PredTakenF  = hit_f && rd_f.cnt[1];
    PredTargetF = PredTakenF ? rd_f.target : PCF + 32'd4;
  end

  // A branch only counts when its slot in E still holds a live prediction.
  assign upd_en      = BranchE && pipe_e.vld;
  assign MispredictE = upd_en &&
                       ((TakenE != pipe_e.pred) || (TakenE && (TargetE != pipe_e.tgt)));
  assign RecoverPCE  = !upd_en ? 32'd0 : (TakenE ? TargetE : pipe_e.pc + 32'd4);

  // NOTE: every output of this block gets a default first so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    hit_e    = rd_e.valid && (rd_e.tag == pc_tag(pipe_e.pc));
    wr_en    = 1'b0;
    wr_entry = rd_e;
    if (upd_en && !reset) begin
      if (hit_e) begin
        wr_en        = 1'b1;
        wr_entry.cnt = cnt_next(rd_e.cnt, TakenE);
        if (TakenE) wr_entry.target = TargetE;
      end else if (TakenE) begin
        wr_en           = 1'b1;
        wr_entry.valid  = 1'b1;
        wr_entry.tag    = pc_tag(pipe_e.pc);
        wr_entry.target = TargetE;
        wr_entry.cnt    = WT;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset || FlushD || MispredictE) begin
      pipe_d <= '0;
    end else if (!StallD) begin
      pipe_d <= '{vld: 1'b1, pred: PredTakenF, tgt: PredTargetF, pc: PCF};
    end
  end

  always_ff @(posedge clk) begin
    if (reset || FlushE || MispredictE) pipe_e <= '0;
    else                                pipe_e <= pipe_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      MispredCount <= '0;
    end else if (MispredictE && (MispredCount != '1)) begin
      MispredCount <= MispredCount + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_branch_predictor_ctrl.sv
// Directed bench for branch_predictor_ctrl: a vector table for training and
// aliasing, then hand-written hysteresis, stall/flush and reset sequences.
module tb_branch_predictor_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PCF;
  logic        StallF, StallD, FlushD, FlushE, BranchE, TakenE;
  logic [31:0] TargetE;
  logic        PredTakenF, MispredictE;
  logic [31:0] PredTargetF, RecoverPCE;
  logic [15:0] MispredCount;
  logic        pt2, mis2;
  logic [31:0] ptgt2, rec2;
  logic [1:0]  cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  branch_predictor_ctrl #(.CNTW(16)) dut (
    .clk(clk), .reset(reset), .PCF(PCF), .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .FlushE(FlushE), .BranchE(BranchE), .TakenE(TakenE),
    .TargetE(TargetE), .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
    .MispredictE(MispredictE), .RecoverPCE(RecoverPCE), .MispredCount(MispredCount)
  );

  // Narrow-counter copy on the same stimulus, used to observe saturation.
  branch_predictor_ctrl #(.CNTW(2)) dut_sat (
    .clk(clk), .reset(reset), .PCF(PCF), .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .FlushE(FlushE), .BranchE(BranchE), .TakenE(TakenE),
    .TargetE(TargetE), .PredTakenF(pt2), .PredTargetF(ptgt2),
    .MispredictE(mis2), .RecoverPCE(rec2), .MispredCount(cnt2)
  );

  typedef struct {
    logic [31:0] pcf;
    logic        sd, fd, fe, br, tk;
    logic [31:0] tgt;
    logic        ept;
    logic [31:0] etgt;
    logic        emis;
    logic [31:0] erec;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(input logic [31:0] pcf, input logic sd, fd, fe, br, tk,
                              input logic [31:0] tgt, input logic ept,
                              input logic [31:0] etgt, input logic emis,
                              input logic [31:0] erec);
    vec_t v;
    v.pcf = pcf; v.sd = sd; v.fd = fd; v.fe = fe; v.br = br; v.tk = tk; v.tgt = tgt;
    v.ept = ept; v.etgt = etgt; v.emis = emis; v.erec = erec;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check the combinational outputs mid-cycle, then
  // advance to just after the next rising edge.
  task automatic step(input vec_t v, input string nm);
    PCF = v.pcf; StallD = v.sd; FlushD = v.fd; FlushE = v.fe;
    BranchE = v.br; TakenE = v.tk; TargetE = v.tgt;
    #1;
    check({nm, "_pt"},  32'(PredTakenF),  32'(v.ept));
    check({nm, "_ptgt"}, PredTargetF,     v.etgt);
    check({nm, "_mis"}, 32'(MispredictE), 32'(v.emis));
    check({nm, "_rec"}, RecoverPCE,       v.erec);
    @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string nm, input int exp_full, input int exp_sat);
    check({nm, "_count"},     32'(MispredCount), 32'(exp_full));
    check({nm, "_count_sat"}, 32'(cnt2),         32'(exp_sat));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; PCF = '0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    FlushE = 1'b0; BranchE = 1'b0; TakenE = 1'b0; TargetE = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_counts("reset", 0, 0);

    // Cold miss, training, target change and aliasing.
    vecs[0]  = mk(32'h100, 0,0,0, 0,0, 32'h000, 0, 32'h104, 0, 32'h000);
    vecs[1]  = mk(32'h004, 0,0,0, 0,0, 32'h000, 0, 32'h008, 0, 32'h000);
    vecs[2]  = mk(32'h008, 0,0,0, 1,1, 32'h200, 0, 32'h00C, 1, 32'h200);
    vecs[3]  = mk(32'h100, 0,0,0, 0,0, 32'h000, 1, 32'h200, 0, 32'h000);
    vecs[4]  = mk(32'h200, 0,0,0, 0,0, 32'h000, 0, 32'h204, 0, 32'h000);
    vecs[5]  = mk(32'h204, 0,0,0, 1,1, 32'h200, 0, 32'h208, 0, 32'h200);
    vecs[6]  = mk(32'h100, 0,0,0, 0,0, 32'h000, 1, 32'h200, 0, 32'h000);
    vecs[7]  = mk(32'h200, 0,0,0, 0,0, 32'h000, 0, 32'h204, 0, 32'h000);
    vecs[8]  = mk(32'h204, 0,0,0, 1,1, 32'h300, 0, 32'h208, 1, 32'h300);
    vecs[9]  = mk(32'h100, 0,0,0, 0,0, 32'h000, 1, 32'h300, 0, 32'h000);
    vecs[10] = mk(32'h140, 0,0,0, 0,0, 32'h000, 0, 32'h144, 0, 32'h000);
    vecs[11] = mk(32'h008, 0,0,0, 1,1, 32'h300, 0, 32'h00C, 0, 32'h300);
    vecs[12] = mk(32'h00C, 0,0,0, 1,0, 32'h000, 0, 32'h010, 0, 32'h144);
    vecs[13] = mk(32'h140, 0,0,0, 0,0, 32'h000, 0, 32'h144, 0, 32'h000);
    vecs[14] = mk(32'h100, 0,0,0, 0,0, 32'h000, 1, 32'h300, 0, 32'h000);
    for (int i = 0; i < 15; i++) step(vecs[i], $sformatf("tbl%0d", i));
    check_counts("tbl", 2, 2);

    // Hysteresis: ST -> WT -> WNT, then a correctly predicted not-taken.
    step(mk(32'h100, 0,0,0, 0,0, 32'h000, 1, 32'h300, 0, 32'h000), "hys0");
    step(mk(32'h004, 0,0,0, 0,0, 32'h000, 0, 32'h008, 0, 32'h000), "hys1");
    step(mk(32'h008, 0,0,0, 1,0, 32'h000, 0, 32'h00C, 1, 32'h104), "hys2");
    step(mk(32'h100, 0,0,0, 0,0, 32'h000, 1, 32'h300, 0, 32'h000), "hys3");
    step(mk(32'h004, 0,0,0, 0,0, 32'h000, 0, 32'h008, 0, 32'h000), "hys4");
    step(mk(32'h008, 0,0,0, 1,0, 32'h000, 0, 32'h00C, 1, 32'h104), "hys5");
    step(mk(32'h100, 0,0,0, 0,0, 32'h000, 0, 32'h104, 0, 32'h000), "hys6");
    step(mk(32'h004, 0,0,0, 0,0, 32'h000, 0, 32'h008, 0, 32'h000), "hys7");
    step(mk(32'h008, 0,0,0, 1,0, 32'h000, 0, 32'h00C, 0, 32'h104), "hys8");
    step(mk(32'h100, 0,0,0, 0,0, 32'h000, 0, 32'h104, 0, 32'h000), "hys9");
    check_counts("hys", 4, 3);

    // Stall D for three cycles while flushing E; stale BranchE must be ignored.
    step(mk(32'h004, 0,1,1, 0,0, 32'h000, 0, 32'h008, 0, 32'h000), "stl0");
    step(mk(32'h108, 0,0,0, 0,0, 32'h000, 0, 32'h10C, 0, 32'h000), "stl1");
    step(mk(32'h004, 0,0,0, 0,0, 32'h000, 0, 32'h008, 0, 32'h000), "stl2");
    step(mk(32'h008, 0,0,0, 1,1, 32'h500, 0, 32'h00C, 1, 32'h500), "stl3");
    step(mk(32'h108, 0,0,0, 0,0, 32'h000, 1, 32'h500, 0, 32'h000), "stl4");
    step(mk(32'h00C, 1,0,1, 0,0, 32'h000, 0, 32'h010, 0, 32'h000), "stl5");
    step(mk(32'h00C, 1,0,1, 1,1, 32'h700, 0, 32'h010, 0, 32'h000), "stl6");
    step(mk(32'h00C, 1,0,1, 1,0, 32'h000, 0, 32'h010, 0, 32'h000), "stl7");
    step(mk(32'h010, 0,0,0, 0,0, 32'h000, 0, 32'h014, 0, 32'h000), "stl8");
    step(mk(32'h014, 0,0,0, 1,1, 32'h500, 0, 32'h018, 0, 32'h500), "stl9");
    step(mk(32'h108, 0,0,0, 0,0, 32'h000, 1, 32'h500, 0, 32'h000), "stl10");
    step(mk(32'h000, 0,0,0, 0,0, 32'h000, 0, 32'h004, 0, 32'h000), "stl11");
    step(mk(32'h100, 0,0,0, 0,0, 32'h000, 0, 32'h104, 0, 32'h000), "stl12");
    check_counts("stl", 5, 3);

    // Reset mid-stream with a branch pending: everything misses afterwards.
    step(mk(32'h108, 0,0,0, 0,0, 32'h000, 1, 32'h500, 0, 32'h000), "rst0");
    reset = 1'b1; PCF = 32'h100; BranchE = 1'b1; TakenE = 1'b1; TargetE = 32'h900;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_counts("rst", 0, 0);
    step(mk(32'h108, 0,0,0, 1,1, 32'h900, 0, 32'h10C, 0, 32'h000), "rst1");
    step(mk(32'h100, 0,0,0, 0,0, 32'h000, 0, 32'h104, 0, 32'h000), "rst2");
    check_counts("rst_end", 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
